// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared core ALU, with round-robin grant.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always wins).
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_op,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_rd,
  output logic            resp0_z,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_op,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_rd,
  output logic            resp1_z,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_rd,
  input  logic            alu_z,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [2:0]      op_q, op_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            z_q, z_d;
  logic            grant0, grant1;
  logic            illegal;
  logic            resp_rdy;

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
`else
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
`endif
  end

  assign illegal  = (op_q == 3'b100) | (op_q == 3'b110) | (op_q == 3'b111);
  assign resp_rdy = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_d    = rd_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          op_d    = grant1 ? req1_op : req0_op;
          owner_d = grant1;
          last_d  = grant1;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT) begin
          // illegal ops are sequenced but report a forced zero result
          rd_d    = illegal ? '0 : alu_rd;
          z_d     = illegal ? 1'b1 : alu_z;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      z_q     <= z_d;
    end
  end

  assign req0_ready  = (state_q == IDLE) & grant0;
  assign req1_ready  = (state_q == IDLE) & grant1;
  assign resp0_valid = (state_q == RESP) & ~owner_q;
  assign resp1_valid = (state_q == RESP) & owner_q;
  assign resp0_rd    = rd_q;
  assign resp0_z     = z_q;
  assign resp1_rd    = rd_q;
  assign resp1_z     = z_q;
  assign alu_rs1     = a_q;
  assign alu_rs2     = b_q;
  assign alu_ctrl    = op_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a one-cycle registered ALU model.
// Fixed-priority checks are selected by ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]      req0_op = '0, req1_op = '0;
  logic            resp0_valid, resp1_valid;
  logic            resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [XLEN-1:0] resp0_rd, resp1_rd;
  logic            resp0_z, resp1_z;
  logic [XLEN-1:0] alu_rs1, alu_rs2, alu_rd;
  logic [2:0]      alu_ctrl;
  logic            alu_z;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         who;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [2:0] c,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
    case (c)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x & y;
      3'b011:  return x | y;
      3'b101:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_rd <= alu_f(alu_ctrl, alu_rs1, alu_rs2);
    alu_z  <= (alu_f(alu_ctrl, alu_rs1, alu_rs2) == 32'd0);
  end

  alu_arbiter #(.XLEN(XLEN), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_rd(resp0_rd), .resp0_z(resp0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_rd(resp1_rd), .resp1_z(resp1_z),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl),
    .alu_rd(alu_rd), .alu_z(alu_z), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_resp(input int who, output int n);
    n = 0;
    while (!(who == 1 ? resp1_valid : resp0_valid) && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input int idx);
    vec_t v;
    int   n;
    int   c;
    v = vecs[idx];
    if (v.who == 0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end
    #1;
    n = 0;
    while (!(v.who == 1 ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("v%0d grant", idx),
        32'(v.who == 1 ? req1_ready : req0_ready), 32'd1);
    c = cyc;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 32'hFFFF_FFFF; req1_a = 32'hFFFF_FFFF;
    wait_resp(v.who, n);
    chk($sformatf("v%0d latency", idx), 32'(cyc - c), 32'd3);
    chk($sformatf("v%0d rd", idx),
        v.who == 1 ? resp1_rd : resp0_rd, v.rd);
    chk($sformatf("v%0d z", idx),
        32'(v.who == 1 ? resp1_z : resp0_z), 32'(v.z));
    chk($sformatf("v%0d other valid", idx),
        32'(v.who == 1 ? resp0_valid : resp1_valid), 32'd0);
    tick();
    chk($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
  endtask

  // one grant with both requesters possibly valid; returns granted index
  task automatic arb_round(input string nm, input int eg,
                           input logic [31:0] erd, output int g);
    int n;
    #1;
    n = 0;
    while (!(req0_ready | req1_ready) && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " one ready"}, 32'(req0_ready & req1_ready), 32'd0);
    g = req1_ready ? 1 : 0;
    chk({nm, " grant"}, 32'(g), 32'(eg));
    tick();
  endtask

  task automatic finish_round(input string nm, input int g,
                              input logic [31:0] erd);
    int n;
    wait_resp(g, n);
    chk({nm, " rd"}, g == 1 ? resp1_rd : resp0_rd, erd);
    tick();
  endtask

  logic [2:0]  ops0[2] = '{3'b010, 3'b101};
  logic [2:0]  ops1[2] = '{3'b011, 3'b010};
  logic [31:0] rr_rd[4] = '{32'd20, 32'd30, 32'd1, 32'd20};

  initial begin
    int g;
    int i0;
    int i1;
    int n;
    vecs[0] = '{0, 3'b000, 32'd20, 32'd30, 32'd50, 1'b0};
    vecs[1] = '{1, 3'b001, 32'd20, 32'd20, 32'd0, 1'b1};
    vecs[2] = '{1, 3'b001, 32'd8, 32'd3, 32'd5, 1'b0};
    vecs[3] = '{0, 3'b010, 32'd20, 32'd30, 32'd20, 1'b0};
    vecs[4] = '{1, 3'b011, 32'd20, 32'd30, 32'd30, 1'b0};
    vecs[5] = '{0, 3'b101, 32'd20, 32'd30, 32'd1, 1'b0};
    vecs[6] = '{0, 3'b111, 32'd5, 32'd5, 32'd0, 1'b1};
    vecs[7] = '{1, 3'b100, 32'd7, 32'd1, 32'd0, 1'b1};
    vecs[8] = '{0, 3'b001, 32'd3, 32'd8, 32'hFFFF_FFFB, 1'b0};
    vecs[9] = '{1, 3'b101, 32'd30, 32'd20, 32'd0, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst rd", resp0_rd, 32'd0);
    chk("rst alu_rs1", alu_rs1, 32'd0);
    chk("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) do_op(i);

`ifdef ALU_ARB_FIXED_PRIO_EN
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd20; req0_b = 32'd30;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'd20; req1_b = 32'd30;
    for (int k = 0; k < 4; k++) begin
      arb_round($sformatf("fp%0d", k), 0, 32'd50, g);
      if (k == 3) req0_valid = 1'b0;
      finish_round($sformatf("fp%0d", k), g, 32'd50);
    end
    arb_round("fp4", 1, 32'd30, g);
    req1_valid = 1'b0;
    finish_round("fp4", g, 32'd30);
`else
    do_reset();
    i0 = 0;
    i1 = 0;
    req0_valid = 1'b1; req0_op = ops0[0]; req0_a = 32'd20; req0_b = 32'd30;
    req1_valid = 1'b1; req1_op = ops1[0]; req1_a = 32'd20; req1_b = 32'd30;
    for (int k = 0; k < 4; k++) begin
      arb_round($sformatf("rr%0d", k), k % 2, rr_rd[k], g);
      if (g == 0) begin
        i0++;
        if (i0 < 2) req0_op = ops0[i0];
        else req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 2) req1_op = ops1[i1];
        else req1_valid = 1'b0;
      end
      finish_round($sformatf("rr%0d", k), g, rr_rd[k]);
    end
`endif

    // response back-pressure: everything held, no new grant
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
    #1;
    chk("bp grant", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b000;
    wait_resp(0, n);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp valid %0d", k), 32'(resp0_valid), 32'd1);
      chk($sformatf("bp rd %0d", k), resp0_rd, 32'd3);
      chk($sformatf("bp z %0d", k), 32'(resp0_z), 32'd0);
      chk($sformatf("bp ready %0d", k),
          32'(req0_ready | req1_ready), 32'd0);
      chk($sformatf("bp busy %0d", k), 32'(busy), 32'd1);
      tick();
    end
    resp0_ready = 1'b1;
    req1_valid = 1'b0;
    tick();
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp release valid", 32'(resp0_valid), 32'd0);

    // reset during EXEC after a req0 grant: last_grant returns to 1
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd4; req0_b = 32'd4;
    #1;
    chk("mr grant", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mr no resp %0d", k),
          32'(resp0_valid | resp1_valid), 32'd0);
      tick();
    end
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd4; req0_b = 32'd4;
    req1_valid = 1'b1; req1_op = 3'b000;
    arb_round("mr contend", 0, 32'd8, g);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    finish_round("mr contend", g, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
